// File: rtl/calc_unit_arbiter.sv
// -----------------------------------------------------------------------------
// calc_unit_arbiter
//
// Shares one fixed-latency 25-tap MAC/bias calculation unit between two layer
// controllers (requester 0 = C1S2 side, requester 1 = C3S4 side).
//
// The unit is granted in round-robin bursts of up to BURST_LEN beats. Every
// accepted beat is launched into the unit on the following cycle, and a small
// tag pipeline remembers who owns each launch so the result can be routed back
// to its owner CALC_LAT+1 cycles after the handshake.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_valid_i/req0_data_i   requester 0 operand bundle {kernel, window, bias}
//   req0_ready_o               requester 0 beat accepted when valid & ready
//   resp0_valid_o/resp0_data_o requester 0 result (single-cycle pulse)
//   req1_* / resp1_*           same for requester 1
//   calc_valid_o/calc_data_o   registered operand launch into the calc unit
//   calc_data_i                result from the calc unit, CALC_LAT after launch
//   busy_o                     grant held or any result still in flight
// -----------------------------------------------------------------------------
module calc_unit_arbiter #(
    parameter int CALC_W    = 816,
    parameter int RES_W     = 16,
    parameter int CALC_LAT  = 7,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid_i,
    input  logic [CALC_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    output logic              resp0_valid_o,
    output logic [RES_W-1:0]  resp0_data_o,

    input  logic              req1_valid_i,
    input  logic [CALC_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic              resp1_valid_o,
    output logic [RES_W-1:0]  resp1_data_o,

    output logic              calc_valid_o,
    output logic [CALC_W-1:0] calc_data_o,
    input  logic [RES_W-1:0]  calc_data_i,

    output logic              busy_o
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int INF_W  = $clog2(CALC_LAT + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                rr_ptr, rr_nxt;          // 0: requester 0 favoured on a tie
    logic [BEAT_W-1:0]   beat_cnt, beat_nxt;

    logic                act_valid;               // valid of the granted requester
    logic                accept;                  // handshake at this edge
    logic                accept_owner;            // owner of the accepted beat
    logic                other_valid;             // valid of the non-granted requester
    logic                burst_done;
    logic                grant_end;

    // Tag pipeline: stage 0 lines up with calc_valid_o, stage CALC_LAT lines
    // up with the matching result on calc_data_i.
    logic [CALC_LAT:0]   tag_valid;
    logic [CALC_LAT:0]   tag_owner;

    logic [INF_W-1:0]    inflight;
    logic                resp_any;

    // -------------------------------------------------------------------------
    // Ready is decoded from the registered state only, so there is no
    // combinational path from any valid to any ready.
    // -------------------------------------------------------------------------
    assign req0_ready_o = (state == GNT0);
    assign req1_ready_o = (state == GNT1);

    assign act_valid    = (state == GNT0) ? req0_valid_i :
                          (state == GNT1) ? req1_valid_i : 1'b0;
    assign accept       = act_valid;
    assign accept_owner = (state == GNT1);
    assign other_valid  = accept_owner ? req0_valid_i : req1_valid_i;
    assign burst_done   = accept && (beat_cnt == BEAT_W'(BURST_LEN - 1));
    // A grant is released either on its last beat or as soon as its owner
    // drops valid, so a short requester never blocks the other side.
    assign grant_end    = (state != IDLE) && (burst_done || !act_valid);

    // -------------------------------------------------------------------------
    // Grant FSM: next state, round-robin pointer and beat counter
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and infers a latch.
        state_nxt = state;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat_cnt;

        case (state)
            IDLE: begin
                if (req0_valid_i && req1_valid_i) begin
                    state_nxt = rr_ptr ? GNT1 : GNT0;
                end else if (req0_valid_i) begin
                    state_nxt = GNT0;
                end else if (req1_valid_i) begin
                    state_nxt = GNT1;
                end
            end

            GNT0, GNT1: begin
                if (accept) begin
                    beat_nxt = beat_cnt + BEAT_W'(1);
                end
                if (grant_end) begin
                    beat_nxt = '0;
                    rr_nxt   = ~accept_owner;
                    // Hand over directly without an idle cycle in between.
                    if (other_valid) begin
                        state_nxt = accept_owner ? GNT0 : GNT1;
                    end else if (burst_done) begin
                        state_nxt = state;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Launch register: one operand bundle per accepted beat
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the wide operand register is reset as well because it is a
        // module output that must read 0 out of reset; it is a single
        // register, not a memory array.
        if (!rst_n) begin
            calc_valid_o <= 1'b0;
            calc_data_o  <= '0;
        end else begin
            calc_valid_o <= accept;
            if (accept) begin
                calc_data_o <= accept_owner ? req1_data_i : req0_data_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tag pipeline and result routing
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            tag_valid <= {tag_valid[CALC_LAT-1:0], accept};
            tag_owner <= {tag_owner[CALC_LAT-1:0], accept_owner};
        end
    end

    // Only the owner's data register is written; the other side keeps its
    // last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_valid_o <= 1'b0;
            resp0_data_o  <= '0;
            resp1_valid_o <= 1'b0;
            resp1_data_o  <= '0;
        end else begin
            resp0_valid_o <= tag_valid[CALC_LAT] && !tag_owner[CALC_LAT];
            resp1_valid_o <= tag_valid[CALC_LAT] &&  tag_owner[CALC_LAT];
            if (tag_valid[CALC_LAT] && !tag_owner[CALC_LAT]) begin
                resp0_data_o <= calc_data_i;
            end
            if (tag_valid[CALC_LAT] && tag_owner[CALC_LAT]) begin
                resp1_data_o <= calc_data_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // In-flight tracking: counts launches (calc_valid_o) that have not yet
    // produced a response pulse. A launch and a response in the same cycle
    // cancel out, which bounds the count at CALC_LAT+1.
    // -------------------------------------------------------------------------
    assign resp_any = resp0_valid_o || resp1_valid_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({calc_valid_o, resp_any})
                2'b10:   inflight <= inflight + INF_W'(1);
                2'b01:   inflight <= inflight - INF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // The launch cycle itself is covered by calc_valid_o so busy never dips
    // between a burst ending in IDLE and the counter picking up that launch.
    assign busy_o = (state != IDLE) || (inflight != '0) || calc_valid_o;

endmodule
